// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port, synchronous-read SRAM between the instruction-fetch
// requester and the data (load/store) requester. At most one SRAM access is
// issued per cycle. Data has fixed priority. A starvation counter forces a
// pending fetch through after STARVE_MAX consecutive data grants. Read data
// is returned exactly one cycle after the access is issued, with no buffering.
//
// Parameters:
//   STARVE_MAX    consecutive data grants allowed while inst_req is high
//                 before the fetch is forced through (legal range 1..15)
//
// Ports:
//   clk           pipeline clock, all state updates on posedge
//   resetn        asynchronous active-low reset
//   inst_req      fetch request, held until inst_addr_ok
//   inst_addr     fetch address (word aligned)
//   inst_addr_ok  fetch accepted this cycle
//   inst_data_ok  fetch response valid this cycle
//   inst_rdata    fetch data, valid with inst_data_ok
//   data_req      load/store request, held until data_addr_ok
//   data_wstrb    byte write strobes, 4'b0000 means read
//   data_addr     load/store address
//   data_wdata    store data
//   data_addr_ok  data request accepted this cycle
//   data_data_ok  data response valid this cycle (stores included)
//   data_rdata    load data, valid with data_data_ok
//   ram_en        SRAM access enable
//   ram_we        SRAM byte write enables
//   ram_addr      SRAM address
//   ram_wdata     SRAM write data
//   ram_rdata     SRAM read data, valid the cycle after ram_en

module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        ram_en,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    StIdle,
    StRespI,
    StRespD
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       run_q;

  logic       force_inst;
  logic       grant_data;
  logic       grant_inst;

  // run_q holds every output low until the first posedge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Grant decision, combinational within the cycle.
  always_comb begin
    force_inst = inst_req & data_req & (starve_q == StarveMax);
    grant_data = run_q & data_req & ~force_inst;
    grant_inst = run_q & inst_req & ~grant_data;
  end

  // Response FSM: the state simply records who was granted last cycle, so
  // back-to-back grants overlap one response with the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StIdle;
    if (grant_data) begin
      state_d = StRespD;
    end else if (grant_inst) begin
      state_d = StRespI;
    end
  end

  // Starvation counter: counts data grants that pass over a waiting fetch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!inst_req || grant_inst) begin
      starve_d = 4'd0;
    end else if (grant_data && (starve_q != StarveMax)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // SRAM request side.
  always_comb begin
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    ram_addr     = 32'd0;
    ram_wdata    = 32'd0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (grant_data) begin
      ram_en       = 1'b1;
      ram_we       = data_wstrb;
      ram_addr     = data_addr;
      ram_wdata    = data_wdata;
      data_addr_ok = 1'b1;
    end else if (grant_inst) begin
      ram_en       = 1'b1;
      ram_addr     = inst_addr;
      inst_addr_ok = 1'b1;
    end
  end

  // Response side: SRAM data is routed straight through to the owner.
  always_comb begin
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
    if (run_q) begin
      unique case (state_q)
        StRespI: begin
          inst_data_ok = 1'b1;
          inst_rdata   = ram_rdata;
        end
        StRespD: begin
          data_data_ok = 1'b1;
          data_rdata   = ram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned STARVE_MAX = 4;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  mem_port_arbiter #(
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM seen by the DUT (64 words, indexed by addr[7:2]).
  logic [31:0] sram [64];
  // Reference copy of memory contents, updated only by the model.
  logic [31:0] ref_mem [64];

  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= sram[ram_addr[7:2]];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) sram[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  bit          run_m;
  int          waited;   // data grants in a row that passed over a waiting fetch
  int          resp_m;   // 0 none, 1 fetch response due, 2 data response due
  bit          resp_store;
  logic [31:0] resp_data;

  task automatic model_reset();
    run_m  = 0;
    waited = 0;
    resp_m = 0;
  endtask

  // One clock cycle: drive inputs at negedge, check outputs, advance the model.
  task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [3:0] ws, input logic [31:0] da, input logic [31:0] wd,
                       input logic rn, output bit ig, output bit dg);
    logic [31:0] word;
    @(negedge clk);
    inst_req   = ir;
    inst_addr  = ia;
    data_req   = dr;
    data_wstrb = ws;
    data_addr  = da;
    data_wdata = wd;
    resetn     = rn;
    #1;
    if (!rn) model_reset();
    dg = run_m && dr && !(ir && dr && (waited == int'(STARVE_MAX)));
    ig = run_m && ir && !dg;

    check_eq("inst_addr_ok", 32'(inst_addr_ok), 32'(ig));
    check_eq("data_addr_ok", 32'(data_addr_ok), 32'(dg));
    check_eq("ram_en", 32'(ram_en), 32'(ig || dg));
    if (dg) begin
      check_eq("ram_addr_d", ram_addr, da);
      check_eq("ram_we_d", 32'(ram_we), 32'(ws));
      check_eq("ram_wdata_d", ram_wdata, wd);
    end else if (ig) begin
      check_eq("ram_addr_i", ram_addr, ia);
      check_eq("ram_we_i", 32'(ram_we), 32'd0);
      check_eq("ram_wdata_i", ram_wdata, 32'd0);
    end else if (!run_m) begin
      check_eq("ram_addr_off", ram_addr, 32'd0);
      check_eq("ram_we_off", 32'(ram_we), 32'd0);
    end
    check_eq("inst_data_ok", 32'(inst_data_ok), 32'(resp_m == 1));
    check_eq("data_data_ok", 32'(data_data_ok), 32'(resp_m == 2));
    check_eq("inst_rdata", inst_rdata, (resp_m == 1) ? resp_data : 32'd0);
    if (!(resp_m == 2 && resp_store))
      check_eq("data_rdata", data_rdata, (resp_m == 2) ? resp_data : 32'd0);

    // Advance the model to the next cycle.
    resp_m = 0;
    if (dg) begin
      word = ref_mem[da[7:2]];
      resp_m     = 2;
      resp_store = (ws != 4'b0000);
      resp_data  = word;
      for (int b = 0; b < 4; b++) if (ws[b]) word[b*8 +: 8] = wd[b*8 +: 8];
      ref_mem[da[7:2]] = word;
      waited = ir ? ((waited < int'(STARVE_MAX)) ? waited + 1 : waited) : 0;
    end else if (ig) begin
      resp_m     = 1;
      resp_store = 0;
      resp_data  = ref_mem[ia[7:2]];
      waited     = 0;
    end else if (!ir) begin
      waited = 0;
    end
    run_m = rn;
  endtask

  bit ig, dg;
  bit ip, dp;
  logic [31:0] ia_p, da_p, wd_p;
  logic [3:0]  ws_p;
  int gi_seq[$];
  int dg_seq[$];

  initial begin
    for (int i = 0; i < 64; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    ram_rdata = 32'd0;
    model_reset();

    // Reset state with random inputs applied.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, $urandom, 1'b1, 4'($urandom), $urandom, $urandom, 1'b0, ig, dg);
    // First cycle after release: still silent.
    cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, ig, dg);

    // Single fetch.
    sram[0] = 32'h02800C0C;
    ref_mem[0] = 32'h02800C0C;
    cycle(1'b1, 32'h1C000000, 1'b0, 0, 0, 0, 1'b1, ig, dg);
    check_eq("fetch_granted", 32'(ig), 32'd1);
    cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, ig, dg);
    check_eq("fetch_rdata", inst_rdata, 32'h02800C0C);

    // Store then load to 0x100.
    cycle(1'b0, 0, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF, 1'b1, ig, dg);
    cycle(1'b0, 0, 1'b1, 4'h0, 32'h100, 0, 1'b1, ig, dg);
    cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, ig, dg);
    check_eq("load_after_store", data_rdata, 32'hDEADBEEF);

    // Contention: data held 6 cycles, fetch waiting.
    ip = 1;
    for (int c = 0; c < 6; c++) begin
      cycle(ip, 32'h40, 1'b1, 4'h0, 32'(c * 4), 0, 1'b1, ig, dg);
      gi_seq.push_back(int'(ig));
      dg_seq.push_back(int'(dg));
      if (ig) ip = 0;
    end
    for (int c = 0; c < 6; c++) begin
      check_eq("starve_inst_grant", 32'(gi_seq[c]), (c == 4) ? 32'd1 : 32'd0);
      check_eq("starve_data_grant", 32'(dg_seq[c]), (c == 4) ? 32'd0 : 32'd1);
    end
    cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, ig, dg);

    // Back-to-back fetches.
    for (int c = 0; c < 3; c++) cycle(1'b1, 32'(c * 4), 1'b0, 0, 0, 0, 1'b1, ig, dg);
    cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, ig, dg);
    cycle(1'b0, 0, 1'b0, 0, 0, 0, 1'b1, ig, dg);

    // Asynchronous reset while a data response is in flight.
    cycle(1'b0, 0, 1'b1, 4'h0, 32'h20, 0, 1'b1, ig, dg);
    @(posedge clk);
    #1;
    check_eq("resp_d_before_reset", 32'(data_data_ok), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("resp_d_dropped", 32'(data_data_ok), 32'd0);
    model_reset();
    cycle(1'b1, 32'h8, 1'b0, 0, 0, 0, 1'b0, ig, dg);
    cycle(1'b1, 32'h8, 1'b0, 0, 0, 0, 1'b1, ig, dg);
    check_eq("no_accept_before_run", 32'(inst_addr_ok), 32'd0);
    cycle(1'b1, 32'h8, 1'b0, 0, 0, 0, 1'b1, ig, dg);
    check_eq("accept_after_run", 32'(inst_addr_ok), 32'd1);

    // Randomized traffic, heavy then light contention.
    ip = 0;
    dp = 0;
    for (int c = 0; c < 800; c++) begin
      int p;
      p = (c < 400) ? 90 : 40;
      if (!ip && $urandom_range(0, 99) < p) begin
        ip   = 1;
        ia_p = {24'h1C0000, 2'($urandom), $urandom_range(0, 63) * 4};
        ia_p[7:0] = 8'($urandom_range(0, 63) * 4);
      end
      if (!dp && $urandom_range(0, 99) < p) begin
        dp   = 1;
        da_p = $urandom;
        da_p[1:0] = 2'b00;
        ws_p = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        wd_p = $urandom;
      end
      cycle(ip, ia_p, dp, ws_p, da_p, wd_p, 1'b1, ig, dg);
      if (ig) ip = 0;
      if (dg) dp = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
